memory_arbiter: RTL and testbench

Single-port main-memory arbiter between the instruction cache (line reads), the data cache (line reads), and the data cache (line write-backs). It sits between the two `cache` instances and the `cpu` memory ports. It serialises the three requesters onto the one `mem_enable`/`mem_rw`/`mem_ack` interface, using fixed priority plus an instruction-side starvation guard. It registers address and write data at grant and returns read data with a one-cycle ack pulse.

---
 rtl/memory_arbiter_pkg.sv | 20 ++
 rtl/memory_arbiter_pick.sv | 21 ++
 rtl/memory_arbiter.sv | 139 +++++++++++++
 tb/tb_memory_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the main-memory arbiter: FSM states, requester IDs, rw codes.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_MEM  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    ARB_ID_NONE = 2'd0,
    ARB_ID_IC   = 2'd1,
    ARB_ID_DCR  = 2'd2,
    ARB_ID_DCW  = 2'd3
  } arb_id_t;

  localparam logic MEM_RW_READ  = 1'b0;
  localparam logic MEM_RW_WRITE = 1'b1;

endpackage

// File: rtl/memory_arbiter_pick.sv
// Winner selection: write-back > fill > I-fetch, unless the I-side has been starved.
module arb_pick
  import memory_arbiter_pkg::*;
(
  input  logic    ic_req,
  input  logic    dcr_req,
  input  logic    dcw_req,
  input  logic    starve_hit,
  output arb_id_t winner
);

  // Fixed priority with the starvation override placed on top.
  always_comb begin
    winner = ARB_ID_NONE;
    if (ic_req && starve_hit) winner = ARB_ID_IC;
    else if (dcw_req)         winner = ARB_ID_DCW;
    else if (dcr_req)         winner = ARB_ID_DCR;
    else if (ic_req)          winner = ARB_ID_IC;
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises I-cache fills, D-cache fills and D-cache write-backs onto one memory port.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int LINE_W       = 128,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_read_req,
  input  logic [ADDR_W-1:0] ic_read_addr,
  output logic              ic_read_ack,
  output logic [LINE_W-1:0] ic_read_data,
  input  logic              dc_read_req,
  input  logic [ADDR_W-1:0] dc_read_addr,
  output logic              dc_read_ack,
  output logic [LINE_W-1:0] dc_read_data,
  input  logic              dc_write_req,
  input  logic [ADDR_W-1:0] dc_write_addr,
  input  logic [LINE_W-1:0] dc_write_data,
  output logic              dc_write_ack,
  output logic              mem_enable,
  output logic              mem_rw,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic [LINE_W-1:0] mem_data_out,
  output logic              arb_busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        state, state_nxt;
  arb_id_t           cur_id, winner;
  logic [CNT_W-1:0]  ic_wait;
  logic              starve_hit;
  logic              grant;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic [LINE_W-1:0] ic_data_q, dc_data_q;

  assign starve_hit = (ic_wait == CNT_W'(STARVE_LIMIT));

  arb_pick u_pick (
    .ic_req     (ic_read_req),
    .dcr_req    (dc_read_req),
    .dcw_req    (dc_write_req),
    .starve_hit (starve_hit),
    .winner     (winner)
  );

  // Requests only count while idle; MEM and RESP ignore them entirely.
  assign grant = (state == ARB_IDLE) && (winner != ARB_ID_NONE);

  assign mem_rw       = rw_q;
  assign mem_addr     = addr_q;
  assign mem_data_out = wdata_q;
  assign ic_read_data = ic_data_q;
  assign dc_read_data = dc_data_q;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the state-decoded strobes (enable, acks, busy).
  always_comb begin
    state_nxt    = state;
    mem_enable   = 1'b0;
    arb_busy     = 1'b1;
    ic_read_ack  = 1'b0;
    dc_read_ack  = 1'b0;
    dc_write_ack = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        arb_busy = 1'b0;
        if (winner != ARB_ID_NONE) state_nxt = ARB_MEM;
      end
      ARB_MEM: begin
        mem_enable = 1'b1;
        if (mem_ack) state_nxt = ARB_RESP;
      end
      ARB_RESP: begin
        ic_read_ack  = (cur_id == ARB_ID_IC);
        dc_read_ack  = (cur_id == ARB_ID_DCR);
        dc_write_ack = (cur_id == ARB_ID_DCW);
        state_nxt    = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Latch winner ID, address and write data at grant; later requester changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_id  <= ARB_ID_NONE;
      rw_q    <= MEM_RW_READ;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      cur_id <= winner;
      rw_q   <= (winner == ARB_ID_DCW) ? MEM_RW_WRITE : MEM_RW_READ;
      unique case (winner)
        ARB_ID_IC:  addr_q <= ic_read_addr;
        ARB_ID_DCR: addr_q <= dc_read_addr;
        ARB_ID_DCW: begin
          addr_q  <= dc_write_addr;
          wdata_q <= dc_write_data;
        end
        default: ;
      endcase
    end
  end

  // Capture read lines on mem_ack; the other port keeps its previous line.
  always_ff @(posedge clk) begin
    if (reset) begin
      ic_data_q <= '0;
      dc_data_q <= '0;
    end else if (state == ARB_MEM && mem_ack) begin
      if (cur_id == ARB_ID_IC)  ic_data_q <= mem_data_in;
      if (cur_id == ARB_ID_DCR) dc_data_q <= mem_data_in;
    end
  end

  // Count D-side grants that overtake a waiting I-fetch; clear on I grant or idle without I request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ic_wait <= '0;
    end else if (state == ARB_IDLE) begin
      if (!ic_read_req || winner == ARB_ID_IC) ic_wait <= '0;
      else if (winner != ARB_ID_NONE && !starve_hit) ic_wait <= ic_wait + 1'b1;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, corner sequences, randomized model check.
module tb_memory_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int SL = 4;
  typedef logic [127:0] w_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ic_read_req = 1'b0, dc_read_req = 1'b0, dc_write_req = 1'b0;
  logic [AW-1:0] ic_read_addr = '0, dc_read_addr = '0, dc_write_addr = '0;
  logic [LW-1:0] dc_write_data = '0;
  logic          ic_read_ack, dc_read_ack, dc_write_ack;
  logic [LW-1:0] ic_read_data, dc_read_data;
  logic          mem_enable, mem_rw, arb_busy;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_data_in = '0, mem_data_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset(reset),
    .ic_read_req(ic_read_req), .ic_read_addr(ic_read_addr),
    .ic_read_ack(ic_read_ack), .ic_read_data(ic_read_data),
    .dc_read_req(dc_read_req), .dc_read_addr(dc_read_addr),
    .dc_read_ack(dc_read_ack), .dc_read_data(dc_read_data),
    .dc_write_req(dc_write_req), .dc_write_addr(dc_write_addr),
    .dc_write_data(dc_write_data), .dc_write_ack(dc_write_ack),
    .mem_enable(mem_enable), .mem_rw(mem_rw), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .arb_busy(arb_busy)
  );

  // Memory model: ack after mem_lat wait cycles of enable; optional stray acks while idle.
  int       mem_lat  = 0;
  int       mem_cnt  = 0;
  bit       spur     = 1'b0;
  bit       rd_fixed = 1'b0;
  w_t       rd_line  = '0;
  always @(negedge clk) begin
    mem_data_in = rd_fixed ? rd_line : {$urandom, $urandom, $urandom, $urandom};
    if (mem_enable) begin
      mem_ack = (mem_cnt == mem_lat);
      mem_cnt++;
    end else begin
      mem_cnt = 0;
      mem_ack = spur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input w_t act, input w_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] acks();
    return {dc_write_ack, dc_read_ack, ic_read_ack};
  endfunction

  // Tick at least once, then until any ack appears (bounded).
  task automatic wait_ack(output logic [2:0] a, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (acks() == 3'b000 && cyc < 40);
    a = acks();
    if (a == 3'b000) chk("ack_timeout", w_t'(0), w_t'(1));
  endtask

  typedef struct {
    bit          ic, dcr, dcw;
    int          lat;
    logic [127:0] rdata;
    logic        exp_rw;
    logic [31:0] exp_addr;
    logic [2:0]  exp_ack;   // {dcw, dcr, ic}
  } vec_t;

  localparam logic [127:0] WDAT = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] WDAT2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;

  vec_t       tbl[7];
  vec_t       v;
  logic [2:0] a;
  int         cyc, en_cnt, lat_cyc;

  // Random-phase model state: transaction timeline in absolute edge numbers.
  bit         rq[3];
  logic [31:0] ra[3];
  w_t         wd;
  int         e, E, free_at, g, L, t_id, cnt, win;
  logic [31:0] t_addr;
  bit         t_rw;
  w_t         t_wd, exp_icd, exp_dcd;
  bit         exp_en, exp_busy;
  logic [2:0] exp_ack;

  initial begin
    tbl[0] = '{1, 0, 0, 3, {16{8'hA5}}, 1'b0, 32'h100, 3'b001};
    tbl[1] = '{0, 1, 0, 0, {16{8'h3C}}, 1'b0, 32'h200, 3'b010};
    tbl[2] = '{0, 0, 1, 1, {16{8'h00}}, 1'b1, 32'h300, 3'b100};
    tbl[3] = '{1, 1, 0, 2, {16{8'h5A}}, 1'b0, 32'h200, 3'b010};
    tbl[4] = '{1, 0, 1, 0, {16{8'h00}}, 1'b1, 32'h300, 3'b100};
    tbl[5] = '{0, 1, 1, 4, {16{8'h00}}, 1'b1, 32'h300, 3'b100};
    tbl[6] = '{1, 1, 1, 1, {16{8'h00}}, 1'b1, 32'h300, 3'b100};

    // Reset values
    tick(); tick();
    chk("rst_strobes", w_t'({mem_enable, mem_rw, acks(), arb_busy}), w_t'(0));
    chk("rst_mem_addr", w_t'(mem_addr), w_t'(0));
    chk("rst_mem_dout", mem_data_out, w_t'(0));
    chk("rst_ic_data", ic_read_data, w_t'(0));
    chk("rst_dc_data", dc_read_data, w_t'(0));
    reset = 1'b0;
    tick();

    // Vector table: one arbitration + transaction per row
    rd_fixed = 1'b1;
    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      rd_line = v.rdata; mem_lat = v.lat;
      ic_read_addr = 32'h100; dc_read_addr = 32'h200; dc_write_addr = 32'h300;
      dc_write_data = WDAT;
      ic_read_req = v.ic; dc_read_req = v.dcr; dc_write_req = v.dcw;
      tick();
      chk("tbl_en", w_t'(mem_enable), w_t'(1));
      chk("tbl_rw", w_t'(mem_rw), w_t'(v.exp_rw));
      chk("tbl_addr", w_t'(mem_addr), w_t'(v.exp_addr));
      if (v.exp_rw) chk("tbl_wdata", mem_data_out, WDAT);
      en_cnt = 0; lat_cyc = 1;
      while (acks() == 3'b000 && lat_cyc < 40) begin
        if (mem_enable) en_cnt++;
        tick();
        lat_cyc++;
      end
      chk("tbl_ack", w_t'(acks()), w_t'(v.exp_ack));
      chk("tbl_latency", w_t'(lat_cyc), w_t'(v.lat + 2));
      chk("tbl_en_cycles", w_t'(en_cnt), w_t'(v.lat + 1));
      chk("tbl_en_at_ack", w_t'(mem_enable), w_t'(0));
      if (v.exp_ack[0]) chk("tbl_ic_data", ic_read_data, v.rdata);
      if (v.exp_ack[1]) chk("tbl_dc_data", dc_read_data, v.rdata);
      ic_read_req = 0; dc_read_req = 0; dc_write_req = 0;
      tick();
      chk("tbl_ack_pulse", w_t'({acks(), arb_busy}), w_t'(0));
    end
    rd_fixed = 1'b0;

    // All three at once: write-back, then fill, then I-fetch
    mem_lat = 1;
    ic_read_req = 1; dc_read_req = 1; dc_write_req = 1;
    for (int k = 0; k < 3; k++) begin
      wait_ack(a, cyc);
      chk("all3_order", w_t'(a), w_t'(3'b100 >> k));
      if (a[0]) ic_read_req = 0;
      if (a[1]) dc_read_req = 0;
      if (a[2]) dc_write_req = 0;
    end
    tick();
    chk("all3_pulse", w_t'(acks()), w_t'(0));

    // Starvation guard: four D grants overtake the I-fetch, the fifth goes to I
    mem_lat = 0;
    ic_read_addr = 32'h440; dc_read_addr = 32'h880;
    ic_read_req = 1; dc_read_req = 1;
    for (int k = 0; k < 5; k++) begin
      wait_ack(a, cyc);
      chk("starve_grant", w_t'(a), (k < 4) ? w_t'(3'b010) : w_t'(3'b001));
      if (k == 3) chk("starve_cnt_full", w_t'(dut.ic_wait), w_t'(SL));
      if (k == 4) chk("starve_cnt_clear", w_t'(dut.ic_wait), w_t'(0));
    end
    ic_read_req = 0; dc_read_req = 0;
    tick(); tick();

    // Reset in the second MEM cycle of a fill, then stray mem_ack while idle
    mem_lat = 5;
    dc_read_addr = 32'h240; dc_read_req = 1;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rstmid_strobes", w_t'({mem_enable, mem_rw, acks(), arb_busy}), w_t'(0));
    chk("rstmid_addr", w_t'(mem_addr), w_t'(0));
    chk("rstmid_data", w_t'(dc_read_data), w_t'(0));
    reset = 1'b0; dc_read_req = 0; spur = 1'b1;
    en_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (mem_enable || acks() != 3'b000 || arb_busy) en_cnt++;
    end
    chk("rstmid_stray_ack", w_t'(en_cnt), w_t'(0));
    spur = 1'b0; mem_lat = 1; dc_read_req = 1;
    wait_ack(a, cyc);
    chk("rstmid_rereq_ack", w_t'(a), w_t'(3'b010));
    chk("rstmid_rereq_lat", w_t'(cyc), w_t'(3));
    dc_read_req = 0;
    tick();

    // Requester changes address/data after grant
    mem_lat = 3;
    dc_write_addr = 32'h300; dc_write_data = WDAT; dc_write_req = 1;
    tick();
    dc_write_addr = 32'hDEAD_0000; dc_write_data = WDAT2;
    en_cnt = 0;
    for (int k = 0; k < 40 && acks() == 3'b000; k++) begin
      if (mem_addr !== 32'h300 || mem_data_out !== WDAT) en_cnt++;
      tick();
    end
    chk("latch_hold", w_t'(en_cnt), w_t'(0));
    chk("latch_ack", w_t'(acks()), w_t'(3'b100));
    chk("latch_addr_resp", w_t'(mem_addr), w_t'(32'h300));
    dc_write_req = 0;
    tick();

    // Randomized traffic against a timeline model
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int r = 0; r < 3; r++) begin rq[r] = 0; ra[r] = '0; end
    wd = '0; e = 0; free_at = 1; g = -1; L = 0; t_id = 0; cnt = 0;
    t_addr = '0; t_rw = 0; t_wd = '0; exp_icd = '0; exp_dcd = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (!rq[r] && $urandom_range(0, 2) == 0) begin rq[r] = 1; ra[r] = $urandom; end
        else if (rq[r] && $urandom_range(0, 5) == 0) ra[r] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) wd = {$urandom, $urandom, $urandom, $urandom};
      spur = ($urandom_range(0, 3) == 0);
      ic_read_req = rq[0]; ic_read_addr = ra[0];
      dc_read_req = rq[1]; dc_read_addr = ra[1];
      dc_write_req = rq[2]; dc_write_addr = ra[2]; dc_write_data = wd;
      E = e + 1;
      if (E >= free_at) begin
        win = -1;
        if (rq[0] && cnt == SL) win = 0;
        else if (rq[2])         win = 2;
        else if (rq[1])         win = 1;
        else if (rq[0])         win = 0;
        if (win >= 0) begin
          L = $urandom_range(0, 4); mem_lat = L;
          g = E; free_at = E + 3 + L; t_id = win;
          t_addr = ra[win]; t_rw = (win == 2);
          if (win == 2) t_wd = wd;
          if (win == 0) cnt = 0;
          else if (rq[0]) cnt++;
        end
        if (!rq[0]) cnt = 0;
      end
      tick();
      e = E;
      exp_en   = (g >= 0) && (e >= g) && (e <= g + L);
      exp_busy = (g >= 0) && (e >= g) && (e <= g + 1 + L);
      exp_ack  = (g >= 0 && e == g + 1 + L) ? (3'b001 << t_id) : 3'b000;
      if (exp_ack != 3'b000) begin
        if (t_id == 0) exp_icd = mem_data_in;
        if (t_id == 1) exp_dcd = mem_data_in;
        rq[t_id] = 0;
      end
      chk("rnd_en", w_t'(mem_enable), w_t'(exp_en));
      chk("rnd_ack", w_t'(acks()), w_t'(exp_ack));
      chk("rnd_busy", w_t'(arb_busy), w_t'(exp_busy));
      if (exp_en) begin
        chk("rnd_rw", w_t'(mem_rw), w_t'(t_rw));
        chk("rnd_addr", w_t'(mem_addr), w_t'(t_addr));
        if (t_rw) chk("rnd_wdata", mem_data_out, t_wd);
      end
      chk("rnd_ic_data", ic_read_data, exp_icd);
      chk("rnd_dc_data", dc_read_data, exp_dcd);
      chk("rnd_ic_wait", w_t'(dut.ic_wait), w_t'(cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
